// File: rtl/pt5_lane_unpacker_pkg.sv
// Shared types and constants for the PT-5 lane unpacker: trit codes,
// byte geometry and the frame sequencer states.
package pt5_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;

  localparam int         TRITS_PER_BYTE = 5;
  localparam logic [7:0] PT5_MAX        = 8'd242;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Base-3 digit (0,1,2) to signed trit code (-1,0,+1).
  function automatic logic [1:0] digit_to_trit(input logic [1:0] digit);
    case (digit)
      2'd0:    digit_to_trit = TRIT_NEG;
      2'd1:    digit_to_trit = TRIT_ZERO;
      2'd2:    digit_to_trit = TRIT_POS;
      default: digit_to_trit = TRIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/pt5_lane_unpacker_if.sv
// Byte-pair input stream and unpacked vector output stream of the unpacker.
interface pt5_lane_unpacker_if #(
  parameter int LANES       = 16,
  parameter int DEPTH_WIDTH = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_weight_byte;
  logic [7:0]             in_input_byte;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*2-1:0]     bus_weights;
  logic [LANES*2-1:0]     bus_inputs;
  logic [DEPTH_WIDTH-1:0] out_depth;

  modport master (
    output in_valid, in_weight_byte, in_input_byte, out_ready,
    input  in_ready, out_valid, bus_weights, bus_inputs, out_depth
  );

  modport slave (
    input  in_valid, in_weight_byte, in_input_byte, out_ready,
    output in_ready, out_valid, bus_weights, bus_inputs, out_depth
  );

endinterface

// File: rtl/pt5_lane_unpacker_byte_decoder.sv
// Combinational PT-5 byte decoder: five base-3 digits, LSD first, mapped to
// 2-bit trits; bytes above 242 decode to zeros and raise invalid_o.
module pt5_byte_decoder
  import pt5_pkg::*;
(
  input  logic [7:0]                  byte_i,
  output logic [2*TRITS_PER_BYTE-1:0] trits_o,
  output logic                        invalid_o
);

  logic [7:0] rem_s;
  logic [1:0] digit_s;

  // Repeated divide-by-3 peels off one digit per trit position.
  always_comb begin
    trits_o   = '0;
    rem_s     = byte_i;
    digit_s   = 2'd0;
    invalid_o = (byte_i > PT5_MAX);
    if (!invalid_o) begin
      for (int k = 0; k < TRITS_PER_BYTE; k++) begin
        digit_s          = 2'(rem_s % 8'd3);
        trits_o[k*2 +: 2] = digit_to_trit(digit_s);
        rem_s            = rem_s / 8'd3;
      end
    end else begin
      trits_o = '0;
    end
  end

endmodule

// File: rtl/pt5_lane_unpacker.sv
// PT-5 lane unpacker: gathers bpv byte pairs per vector into LANES-wide trit
// staging, then holds the vector until accepted, for depth_total vectors.
module pt5_lane_unpacker
  import pt5_pkg::*;
#(
  parameter int LANES       = 16,
  parameter int DEPTH_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DEPTH_WIDTH-1:0] depth_total,
  input  logic [15:0]            lane_count,
  output logic                   busy,
  output logic                   done,
  output logic                   decode_err,
  pt5_lane_unpacker_if.slave     bus
);

  localparam int          BPV_MAX = (LANES + TRITS_PER_BYTE - 1) / TRITS_PER_BYTE;
  localparam int          BIDX_W  = (BPV_MAX > 1) ? $clog2(BPV_MAX) : 1;
  localparam logic [15:0] LANES16 = 16'(LANES);

  state_e                 state_q, state_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic [DEPTH_WIDTH-1:0] depth_total_q, depth_total_d;
  logic [15:0]            eff_lanes_q, eff_lanes_d;
  logic [BIDX_W-1:0]      bpv_m1_q, bpv_m1_d;
  logic [BIDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [LANES*2-1:0]     wts_q, wts_d;
  logic [LANES*2-1:0]     ins_q, ins_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [15:0]                 eff_lanes_s;
  logic [BIDX_W-1:0]           bpv_m1_s;
  logic [2*TRITS_PER_BYTE-1:0] w_trits_s, i_trits_s;
  logic                        w_inv_s, i_inv_s;

  pt5_byte_decoder u_dec_weight (
    .byte_i    (bus.in_weight_byte),
    .trits_o   (w_trits_s),
    .invalid_o (w_inv_s)
  );

  pt5_byte_decoder u_dec_input (
    .byte_i    (bus.in_input_byte),
    .trits_o   (i_trits_s),
    .invalid_o (i_inv_s)
  );

  // Effective lane count and (bytes per vector - 1) derived from lane_count.
  always_comb begin
    if (lane_count == 16'd0 || lane_count > LANES16) begin
      eff_lanes_s = LANES16;
    end else begin
      eff_lanes_s = lane_count;
    end
    bpv_m1_s = BIDX_W'((eff_lanes_s - 16'd1) / 16'(TRITS_PER_BYTE));
  end

  // Frame sequencer next-state and staging updates.
  always_comb begin
    state_d       = state_q;
    depth_d       = depth_q;
    depth_total_d = depth_total_q;
    eff_lanes_d   = eff_lanes_q;
    bpv_m1_d      = bpv_m1_q;
    byte_idx_d    = byte_idx_q;
    wts_d         = wts_q;
    ins_d         = ins_q;
    done_d        = 1'b0;
    err_d         = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d         = 1'b0;
          depth_d       = '0;
          byte_idx_d    = '0;
          depth_total_d = depth_total;
          eff_lanes_d   = eff_lanes_s;
          bpv_m1_d      = bpv_m1_s;
          if (depth_total != '0) begin
            state_d = FILL;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      FILL: begin
        if (bus.in_valid) begin
          // First byte of a vector starts from clean staging so stale lanes never leak.
          if (byte_idx_q == '0) begin
            wts_d = '0;
            ins_d = '0;
          end else begin
            wts_d = wts_q;
            ins_d = ins_q;
          end
          for (int l = 0; l < LANES; l++) begin
            if (byte_idx_q == BIDX_W'(l / TRITS_PER_BYTE) && 16'(l) < eff_lanes_q) begin
              wts_d[l*2 +: 2] = w_trits_s[(l % TRITS_PER_BYTE)*2 +: 2];
              ins_d[l*2 +: 2] = i_trits_s[(l % TRITS_PER_BYTE)*2 +: 2];
            end else begin
              wts_d[l*2 +: 2] = wts_d[l*2 +: 2];
              ins_d[l*2 +: 2] = ins_d[l*2 +: 2];
            end
          end
          err_d = err_q | w_inv_s | i_inv_s;
          if (byte_idx_q == bpv_m1_q) begin
            state_d = HOLD;
          end else begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
          end
        end else begin
          state_d = FILL;
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          byte_idx_d = '0;
          if (depth_q == depth_total_q - DEPTH_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            depth_d = depth_q + DEPTH_WIDTH'(1);
            state_d = FILL;
          end
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and staging registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      depth_q       <= '0;
      depth_total_q <= '0;
      eff_lanes_q   <= '0;
      bpv_m1_q      <= '0;
      byte_idx_q    <= '0;
      wts_q         <= '0;
      ins_q         <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      depth_q       <= depth_d;
      depth_total_q <= depth_total_d;
      eff_lanes_q   <= eff_lanes_d;
      bpv_m1_q      <= bpv_m1_d;
      byte_idx_q    <= byte_idx_d;
      wts_q         <= wts_d;
      ins_q         <= ins_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.in_ready    = (state_q == FILL);
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.bus_weights = wts_q;
  assign bus.bus_inputs  = ins_q;
  assign bus.out_depth   = depth_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign decode_err      = err_q;

endmodule

// File: tb/tb_pt5_lane_unpacker.sv
// Directed bench for pt5_lane_unpacker: single-vector table plus hand-written
// multi-vector, backpressure, empty-frame and mid-frame reset sequences.
module tb_pt5_lane_unpacker;

  localparam int LANES = 16;
  localparam int DW    = 16;

  logic          clk         = 1'b0;
  logic          reset       = 1'b0;
  logic          start       = 1'b0;
  logic [DW-1:0] depth_total = '0;
  logic [15:0]   lane_count  = 16'd0;
  logic          busy, done, decode_err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  pt5_lane_unpacker_if #(.LANES(LANES), .DEPTH_WIDTH(DW)) bus ();

  pt5_lane_unpacker #(.LANES(LANES), .DEPTH_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .depth_total (depth_total),
    .lane_count  (lane_count),
    .busy        (busy),
    .done        (done),
    .decode_err  (decode_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // done pulses are counted mid-cycle; busy must never be high alongside one.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL done_busy_exclusive busy=%0b required=0", busy);
      end
    end
  end

  typedef struct packed {
    logic [15:0]     lc;
    logic [2:0]      nb;
    logic [3:0][7:0] wb;   // byte3..byte0
    logic [3:0][7:0] ib;
    logic [31:0]     ew;
    logic [31:0]     ei;
    logic            err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [DW-1:0] dt, input logic [15:0] lc);
    start       = 1'b1;
    depth_total = dt;
    lane_count  = lc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] w, input logic [7:0] x);
    int n;
    n = 0;
    bus.in_valid       = 1'b1;
    bus.in_weight_byte = w;
    bus.in_input_byte  = x;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_weight_byte = 8'd0;
    bus.in_input_byte  = 8'd0;
    bus.out_ready      = 1'b0;

    vecs[0] = '{lc: 16'd16, nb: 3'd4, wb: {8'd1, 8'd242, 8'd121, 8'd0},
                ib: {8'd2, 8'd121, 8'd0, 8'd242},
                ew: 32'h155003FF, ei: 32'h400FFD55, err: 1'b0};
    vecs[1] = '{lc: 16'd7, nb: 3'd2, wb: {8'd0, 8'd0, 8'd242, 8'd242},
                ib: {8'd0, 8'd0, 8'd0, 8'd0},
                ew: 32'h00001555, ei: 32'h00003FFF, err: 1'b0};
    vecs[2] = '{lc: 16'd0, nb: 3'd4, wb: {8'd242, 8'd242, 8'd242, 8'd242},
                ib: {8'd0, 8'd0, 8'd0, 8'd0},
                ew: 32'h55555555, ei: 32'hFFFFFFFF, err: 1'b0};
    vecs[3] = '{lc: 16'd20, nb: 3'd4, wb: {8'd121, 8'd121, 8'd121, 8'd5},
                ib: {8'd5, 8'd121, 8'd121, 8'd121},
                ew: 32'h000003F1, ei: 32'h40000000, err: 1'b0};
    vecs[4] = '{lc: 16'd16, nb: 3'd4, wb: {8'd242, 8'd242, 8'd242, 8'd250},
                ib: {8'd121, 8'd121, 8'd121, 8'd121},
                ew: 32'h55555400, ei: 32'h00000000, err: 1'b1};
    vecs[5] = '{lc: 16'd1, nb: 3'd1, wb: {8'd0, 8'd0, 8'd0, 8'd0},
                ib: {8'd0, 8'd0, 8'd0, 8'd242},
                ew: 32'h00000003, ei: 32'h00000001, err: 1'b0};
    vecs[6] = '{lc: 16'd5, nb: 3'd1, wb: {8'd0, 8'd0, 8'd0, 8'd5},
                ib: {8'd0, 8'd0, 8'd0, 8'd0},
                ew: 32'h000003F1, ei: 32'h000003FF, err: 1'b0};
    vecs[7] = '{lc: 16'd6, nb: 3'd2, wb: {8'd0, 8'd0, 8'd0, 8'd0},
                ib: {8'd0, 8'd0, 8'd242, 8'd242},
                ew: 32'h00000FFF, ei: 32'h00000555, err: 1'b0};

    // Reset held low for three cycles.
    reset = 1'b0;
    tick(); tick(); tick();
    check("rst_in_ready",   {63'd0, bus.in_ready},  64'd0);
    check("rst_out_valid",  {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy",       {63'd0, busy},          64'd0);
    check("rst_done",       {63'd0, done},          64'd0);
    check("rst_decode_err", {63'd0, decode_err},    64'd0);
    check("rst_weights",    64'(bus.bus_weights),   64'd0);
    check("rst_inputs",     64'(bus.bus_inputs),    64'd0);
    check("rst_depth",      64'(bus.out_depth),     64'd0);
    reset = 1'b1;
    tick();
    check("idle_in_ready", {63'd0, bus.in_ready}, 64'd0);

    // Single-vector frames from the table.
    for (int v = 0; v < 8; v++) begin
      start_frame(16'd1, vecs[v].lc);
      check("vec_in_ready", {63'd0, bus.in_ready}, 64'd1);
      for (int b = 0; b < int'(vecs[v].nb); b++) begin
        send_pair(vecs[v].wb[b], vecs[v].ib[b]);
      end
      check("vec_out_valid",  {63'd0, bus.out_valid}, 64'd1);
      check("vec_hold_ready", {63'd0, bus.in_ready},  64'd0);
      check("vec_weights",    64'(bus.bus_weights),   64'(vecs[v].ew));
      check("vec_inputs",     64'(bus.bus_inputs),    64'(vecs[v].ei));
      check("vec_depth",      64'(bus.out_depth),     64'd0);
      check("vec_decode_err", {63'd0, decode_err},    {63'd0, vecs[v].err});
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("vec_done", {63'd0, done}, 64'd1);
      check("vec_busy", {63'd0, busy}, 64'd0);
      check("vec_err_after", {63'd0, decode_err}, {63'd0, vecs[v].err});
      tick();
      check("vec_done_pulse", {63'd0, done}, 64'd0);
    end

    // Three-vector frame, backpressure, start and depth_total changes in HOLD.
    done_cnt = 0;
    start_frame(16'd3, 16'd5);
    for (int d = 0; d < 3; d++) begin
      logic [7:0]  wbyte;
      logic [31:0] wexp;
      case (d)
        0:       begin wbyte = 8'd0;   wexp = 32'h000003FF; end
        1:       begin wbyte = 8'd121; wexp = 32'h00000000; end
        default: begin wbyte = 8'd242; wexp = 32'h00000155; end
      endcase
      send_pair(wbyte, 8'd5);
      check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      start       = 1'b1;
      depth_total = 16'd1;
      for (int c = 0; c < 5; c++) begin
        tick();
        check("bp_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("bp_out_valid_hold", {63'd0, bus.out_valid}, 64'd1);
        check("bp_weights",   64'(bus.bus_weights),   64'(wexp));
        check("bp_inputs",    64'(bus.bus_inputs),    64'h3F1);
        check("bp_depth",     64'(bus.out_depth),     64'(d));
      end
      start         = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      if (d < 2) begin
        check("bp_refill_ready", {63'd0, bus.in_ready}, 64'd1);
        check("bp_mid_done",     {63'd0, done},         64'd0);
      end else begin
        check("bp_last_done", {63'd0, done}, 64'd1);
        check("bp_last_busy", {63'd0, busy}, 64'd0);
      end
    end
    tick();
    check("bp_done_after", {63'd0, done}, 64'd0);
    check("bp_done_count", 64'(done_cnt), 64'd1);

    // Empty frame: done pulse only, never ready for bytes.
    start_frame(16'd0, 16'd16);
    check("dt0_done",     {63'd0, done},         64'd1);
    check("dt0_busy",     {63'd0, busy},         64'd0);
    check("dt0_in_ready", {63'd0, bus.in_ready}, 64'd0);
    tick();
    check("dt0_done_pulse", {63'd0, done},         64'd0);
    check("dt0_in_ready2",  {63'd0, bus.in_ready}, 64'd0);

    // Reset in the middle of FILL after an invalid byte.
    start_frame(16'd2, 16'd16);
    send_pair(8'd250, 8'd0);
    check("mid_err_set",  {63'd0, decode_err},   64'd1);
    check("mid_in_ready", {63'd0, bus.in_ready}, 64'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
    check("mid_rst_busy",      {63'd0, busy},          64'd0);
    check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mid_rst_err",       {63'd0, decode_err},    64'd0);
    check("mid_rst_weights",   64'(bus.bus_weights),   64'd0);
    check("mid_rst_inputs",    64'(bus.bus_inputs),    64'd0);
    reset = 1'b1;
    tick();
    check("mid_rst_idle", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pt5_lane_unpacker.md
Name: pt5_lane_unpacker

Overview:
Upstream feeder for the vector engine. Consumes paired PT-5 packed byte streams: weight bytes and input bytes, each byte carrying 5 base-3 trits. Unpacks them into per-lane 2-bit trits and presents one LANES-wide vector per beat on bus_weights/bus_inputs. Sequences a frame of depth_total vectors and tags each with its depth index, so lane address = depth*LANES + lane_id.

Parameters:
LANES, 16, SIMD width; must match the downstream vector engine.
DEPTH_WIDTH, 16, width of the depth counter and depth_total.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  begin frame; sampled only in IDLE
depth_total  input  DEPTH_WIDTH  vectors per frame; latched on start
lane_count  input  16  active lanes; latched on start
in_valid  input  1  byte pair valid
in_ready  output  1  byte pair accepted when in_valid && in_ready
in_weight_byte  input  8  PT-5 weight byte
in_input_byte  input  8  PT-5 input byte
out_valid  output  1  vector valid
out_ready  input  1  downstream accepts vector
bus_weights  output  LANES*2  unpacked weight trits, lane i at [i*2+:2]
bus_inputs  output  LANES*2  unpacked input trits
out_depth  output  DEPTH_WIDTH  depth index of the presented vector
busy  output  1  high in FILL or HOLD
done  output  1  one-cycle pulse at frame end
decode_err  output  1  sticky; set on any byte >242; cleared by accepted start

Behaviour:
- Reset (reset==0 at posedge): state=IDLE. All outputs are 0. Staging registers, depth and byte_idx are 0. Any in-flight frame is discarded.
- Trit encoding: 2'b00=0, 2'b01=+1, 2'b11=-1; 2'b10 is never produced.
- PT-5 decode: digit k = floor(byte/3^k) mod 3, k=0..4, LSD first. Digit 0 maps to -1, 1 to 0, 2 to +1.
- A byte in 243..255 decodes to five 2'b00 trits and sets decode_err.
- eff_lanes = LANES if lane_count==0 or lane_count>LANES, else lane_count. bpv = ceil(eff_lanes/5). Both are latched on start.
- IDLE: in_ready=0, out_valid=0.
  - start with depth_total!=0: clear decode_err, depth=0, byte_idx=0, go to FILL.
  - start with depth_total==0: done pulses the next cycle; state stays IDLE.
- FILL: in_ready=1. On handshake:
  - Trits k of both bytes are written to lanes byte_idx*5+k.
  - Lanes >= eff_lanes are forced to 00. Trits mapping to lanes >= LANES are dropped.
  - If byte_idx==0, all staging lanes are cleared before the write.
  - If byte_idx==bpv-1: go to HOLD and assert out_valid the next cycle. Otherwise byte_idx++.
- HOLD: out_valid=1, in_ready=0. bus_*/out_depth stay stable until accepted.
  - On out_ready: byte_idx=0.
  - If depth==depth_total-1: go to IDLE, done=1 for one cycle.
  - Otherwise depth++ and go to FILL.
- Throughput: one vector per bpv+1 cycles minimum. Each vector's first byte is accepted at the earliest one cycle after the out handshake.
- start outside IDLE is ignored. The depth counter wraps only via depth_total, never internally.
- busy = state!=IDLE. done and busy are never both high.

Decomposition:
- Package pt5_pkg:
  - Trit localparams TRIT_ZERO/TRIT_POS/TRIT_NEG.
  - TRITS_PER_BYTE=5, PT5_MAX=242.
  - State enum IDLE/FILL/HOLD.
- Sub-module pt5_byte_decoder: combinational, 8-bit byte in, 10-bit trit vector plus invalid flag out. Instantiated twice (weight, input).

Test Plan:
- Reset/idle: hold reset low 3 cycles, then release -> all outputs 0, in_ready=0, busy=0.
- Single vector, LANES=16, lane_count=16, depth_total=1:
  - Weight bytes 0,121,242,1 -> lanes0-4 = 11, lanes5-9 = 00, lanes10-14 = 01, lane15 = 00 (byte 1: lane15 gets digit0=1 -> 0).
  - out_valid after the 4th byte; out_depth=0; done pulses one cycle after out_ready.
- Partial lanes: lane_count=7, inputs 242,242 -> bpv=2; lanes0-6 = 01, lanes7-15 = 00; lane_count=0 behaves as 16.
- Backpressure: out_ready low 5 cycles in HOLD -> in_ready=0, bus_*/out_depth stable; depth_total=3 -> out_depth 0,1,2, done once.
- Invalid byte 250 in weights -> those 5 lanes = 00, decode_err stays high through the frame, cleared by the next start.
- Edge cases:
  - depth_total=0 -> done pulse, no in_ready.
  - reset low mid-FILL -> immediately IDLE, outputs 0.
  - start during HOLD -> ignored.
